// File: rtl/config_loader_if.sv
`default_nettype none
// ============================================================================
// config_loader_if : start/abort control, serial bit stream and latch bus
// Rev 1.0
// ============================================================================
interface config_loader_if #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 4
);
  logic                  start;
  logic                  abort;
  logic                  bit_valid;
  logic                  bit_in;
  logic                  bit_ready;
  logic [MEM_SIZE-1:0]   config_out;
  logic [NUM_BLOCKS-1:0] comb_set;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, abort, bit_valid, bit_in,
    input  bit_ready, config_out, comb_set, busy, done, err
  );

  modport slave (
    input  start, abort, bit_valid, bit_in,
    output bit_ready, config_out, comb_set, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// config_loader : serial bitstream to MEM_SIZE-bit words, strobed one-hot into
// NUM_BLOCKS latch blocks. CFG_LOADER_PARITY_EN appends an even-parity bit.
// Rev 1.0
// ============================================================================
module config_loader #(
  parameter int ADDR_BITS  = 4,
  parameter int MEM_SIZE   = 2**ADDR_BITS,
  parameter int NUM_BLOCKS = 4,
  parameter int CNT_BITS   = 8
) (
  input wire logic        clk,
  input wire logic        rst_n,
  config_loader_if.slave  bus
);
  localparam int BLK_BITS = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
`ifdef CFG_LOADER_PARITY_EN
  localparam int WORD_BITS = MEM_SIZE + 1;
`else
  localparam int WORD_BITS = MEM_SIZE;
`endif
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WORD_BITS - 1);
  localparam logic [CNT_BITS-1:0] DATA_CNT = CNT_BITS'(MEM_SIZE);
  localparam logic [BLK_BITS-1:0] LAST_BLK = BLK_BITS'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [BLK_BITS-1:0] blk_q, blk_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [MEM_SIZE-1:0] shift_q, shift_d;
  logic [MEM_SIZE-1:0] config_q, config_d;
  logic [MEM_SIZE-1:0] shift_next;
  logic                accept;
`ifdef CFG_LOADER_PARITY_EN
  logic                err_q, err_d;
`endif

  // LSB-first: after MEM_SIZE right shifts, bit k sits at shift_q[k]
  assign shift_next = {bus.bit_in, shift_q[MEM_SIZE-1:1]};
  assign accept     = (state_q == S_SHIFT) && bus.bit_valid;

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    config_d = config_q;
`ifdef CFG_LOADER_PARITY_EN
    err_d    = err_q;
`endif
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_SHIFT;
            blk_d   = '0;
            cnt_d   = '0;
            shift_d = '0;
`ifdef CFG_LOADER_PARITY_EN
            err_d   = 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (accept) begin
            cnt_d = cnt_q + CNT_BITS'(1);
            if (cnt_q < DATA_CNT) begin
              shift_d = shift_next;
            end
            // Loading config_out on entry to SETUP keeps it stable through STROBE
            if (cnt_q == LAST_CNT) begin
`ifdef CFG_LOADER_PARITY_EN
              if (bus.bit_in == ^shift_q) begin
                config_d = shift_q;
                state_d  = S_SETUP;
              end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
`else
              config_d = shift_next;
              state_d  = S_SETUP;
`endif
            end
          end
        end
        S_SETUP:  state_d = S_STROBE;
        S_STROBE: state_d = S_HOLD;
        S_HOLD: begin
          if (blk_q == LAST_BLK) begin
            state_d = S_DONE;
          end else begin
            blk_d   = blk_q + BLK_BITS'(1);
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      blk_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      config_q <= '0;
`ifdef CFG_LOADER_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      config_q <= config_d;
`ifdef CFG_LOADER_PARITY_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    bus.bit_ready = (state_q == S_SHIFT);
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE) && !bus.abort;
    bus.comb_set  = '0;
    if ((state_q == S_STROBE) && !bus.abort) begin
      bus.comb_set = NUM_BLOCKS'(1) << blk_q;
    end
  end

  assign bus.config_out = config_q;
`ifdef CFG_LOADER_PARITY_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/config_loader.md
Name: config_loader

Overview:
- Serial-to-parallel configuration loader: the write side of the block-style config latch interface.
- Accepts a serial bitstream through a valid/ready handshake and assembles MEM_SIZE-bit LUT words.
- Drives the shared config_in bus and a one-hot comb_set strobe to NUM_BLOCKS latch blocks in a SLICEL, one block at a time.
- Sits between the fabric-level config shift chain and the per-LUT config latch blocks.

Parameters:
- ADDR_BITS, 4, LUT input count; must match the target latch blocks.
- MEM_SIZE, 2**ADDR_BITS, bits per latch block word.
- NUM_BLOCKS, 4, number of latch blocks loaded per frame.
- CNT_BITS, 8, width of the internal bit counter; must satisfy 2**CNT_BITS > MEM_SIZE.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a frame load when idle.
- abort  input  1  synchronous cancel of the current frame.
- bit_valid  input  1  serial bit on bit_in is valid.
- bit_in  input  1  serial config bit.
- bit_ready  output  1  loader accepts a bit this cycle.
- config_out  output  MEM_SIZE  parallel word to the config_in bus of the latch blocks.
- comb_set  output  NUM_BLOCKS  one-hot latch strobe; bit b targets block b.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse after the last block is committed.
- err  output  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; config_out=0, comb_set=0, bit_ready=0, busy=0, done=0, err=0; internal counters and shift register cleared.
- States: IDLE, SHIFT, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - start=1 moves to SHIFT, sets block index to 0, bit count to 0, and clears err.
  - start is ignored in every other state.
- SHIFT:
  - bit_ready=1.
  - A bit is accepted when bit_valid && bit_ready. The k-th accepted bit of a word (k=0..MEM_SIZE-1) lands in shift_reg[k] (LSB first).
  - Cycles with bit_valid=0 stall with no state change.
  - On acceptance of bit MEM_SIZE-1, go to SETUP next cycle.
- SETUP (1 cycle):
  - bit_ready=0; config_out loads shift_reg; comb_set=0.
  - This gives one cycle of data setup ahead of the strobe.
- STROBE (1 cycle): comb_set[block index]=1 with all other bits 0; config_out held.
- HOLD (1 cycle):
  - comb_set=0; config_out held (one cycle of hold after the strobe).
  - If block index == NUM_BLOCKS-1, go to DONE. Otherwise increment block index, clear bit count, and return to SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE. config_out keeps the last word until the next SETUP.
- Per-frame latency: NUM_BLOCKS*(MEM_SIZE accepted bits + 3) + 1 cycles from the first SHIFT cycle to the done pulse, with no stalls.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and comb_set is forced to 0 that same cycle.
  - Latch blocks already strobed keep their contents; the partial word is discarded and never strobed.
  - done is not pulsed; err is unchanged.
- abort and start in the same cycle while IDLE: abort wins and the loader stays in IDLE.
- comb_set is never multi-hot and is never asserted in the same cycle that config_out changes.
- bit_ready is 0 outside SHIFT. Bits presented then are not consumed.

Optional Feature:
- Macro: CFG_LOADER_PARITY_EN.
- Defined:
  - Each word is followed by one extra accepted bit in SHIFT, the even-parity bit over the MEM_SIZE data bits.
  - On match, proceed to SETUP.
  - On mismatch, set err=1, skip SETUP/STROBE/HOLD (no comb_set), and go to IDLE without done.
  - Per-word bit count becomes MEM_SIZE+1.
- Undefined: no parity bit; err is tied to 0.

Test Plan:
- Reset mid-SHIFT after 5 bits: rst_n low → all outputs 0 immediately; after release, busy=0 and bit_ready=0.
- Full frame, MEM_SIZE=16, NUM_BLOCKS=4, words 0xA5C3, 0x0001, 0x8000, 0xFFFF sent LSB first, bit_valid always 1:
  - comb_set pulses 0001, 0010, 0100, 1000 in order, each while config_out holds the matching word.
  - done pulses at cycle 4*19+1 = 77.
- Stalls: bit_valid low every other cycle with word 0x1234 → same config_out/comb_set sequence; bit count advances only on accepted bits.
- Abort after block 1 is strobed and 7 bits of word 2 are in: comb_set stays 0, done never asserts, busy=0 next cycle; a new start reloads from block 0.
- start during busy and start+abort while idle: both ignored; no state change.
- CFG_LOADER_PARITY_EN:
  - Word 0x0003 with parity 0 → strobe as normal.
  - Word 0x0007 with parity 0 → err=1, no comb_set, IDLE.
  - A following start clears err.
